hilo_muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for the HI/LO multiply/divide resource.
- Replaces the single-cycle MULTU/DIVU path in the ALU with an iterative shift-add multiplier and restoring divider.
- Sits beside the ALU. The CPU control FSM issues an operation through a start/busy/done handshake. MFHI/MFLO read the hi/lo outputs; MTHI/MTLO write them directly.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/hilo_muldiv_ctrl.sv | 140 ++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Signed variants are the even encodings.
    function automatic logic op_is_signed(op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of LSB-first shift-add multiply or restoring divide.
// The 2*XLEN accumulator holds {upper, lower}: product halves for
// multiply, {remainder, quotient-in-progress} for divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   partial;
    logic [XLEN-1:0] diff;

    // Single combinational step; the shared accumulator keeps both paths narrow.
    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
        partial  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        // The true difference is below 2**XLEN whenever it is used.
        diff     = partial[XLEN-1:0] - operand;
        acc_next = {1'b0, acc[2*XLEN-1:1]};
        if (is_div) begin
            if (partial >= {1'b0, operand})
                acc_next = {diff, acc[XLEN-2:0], 1'b1};
            else
                acc_next = {partial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide sequencer with MTHI/MTLO write port.
// Operands are reduced to magnitudes at start, iterated XLEN times, and
// the signs are restored in a single fix-up cycle before commit.
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e            state, state_next;
    op_e               op_q;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   a_raw;
    logic [XLEN-1:0]   operand;
    logic [2*XLEN-1:0] acc, acc_next;
    logic [CNT_W-1:0]  cnt;
    logic              dbz_q;

    logic              start_signed;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quot_fixed, rem_fixed;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (op_is_div(op_q)),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // Magnitudes at start and sign-restored results at fix-up.
    always_comb begin
        start_signed = op_is_signed(op_e'(op));
        mag_a        = (start_signed && a[XLEN-1]) ? -a : a;
        mag_b        = (start_signed && b[XLEN-1]) ? -b : b;
        prod_fixed   = (sign_a ^ sign_b) ? -acc : acc;
        quot_fixed   = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fixed    = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state: fixed XLEN-step run, no early exit (including divide by zero).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt == '0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        div_by_zero = (state == ST_DONE) && dbz_q;
    end

    // Datapath: operand capture, iteration, fix-up commit and MTHI/MTLO writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= OP_MULT;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            a_raw   <= '0;
            operand <= '0;
            acc     <= '0;
            cnt     <= '0;
            dbz_q   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        op_q   <= op_e'(op);
                        sign_a <= start_signed && a[XLEN-1];
                        sign_b <= start_signed && b[XLEN-1];
                        a_raw  <= a;
                        cnt    <= CNT_W'(XLEN - 1);
                        dbz_q  <= 1'b0;
                        // Multiply iterates over b's bits adding |a|; divide shifts |a| out against |b|.
                        if (op_is_div(op_e'(op))) begin
                            operand <= mag_b;
                            acc     <= {{XLEN{1'b0}}, mag_a};
                        end else begin
                            operand <= mag_a;
                            acc     <= {{XLEN{1'b0}}, mag_b};
                        end
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    if (!op_is_div(op_q)) begin
                        hi <= prod_fixed[2*XLEN-1:XLEN];
                        lo <= prod_fixed[XLEN-1:0];
                    end else if (operand == '0) begin
                        hi    <= a_raw;
                        lo    <= '1;
                        dbz_q <= 1'b1;
                    end else begin
                        hi <= rem_fixed;
                        lo <= quot_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed corner cases plus
// random operations compared against a plain-arithmetic reference model.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Reference: 64-bit integer arithmetic; C-style truncating division.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dbz);
        longint sx, sy, p, q, r;
        logic [63:0] pv, qv, rv;
        if (o == 2'd0 || o == 2'd2) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end
        e_dbz = 1'b0;
        if (o < 2'd2) begin
            p = sx * sy;
            pv = p;
            e_hi = pv[63:32];
            e_lo = pv[31:0];
        end else if (y == 32'd0) begin
            e_hi  = x;
            e_lo  = 32'hFFFF_FFFF;
            e_dbz = 1'b1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            qv = q;
            rv = r;
            e_hi = rv[31:0];
            e_lo = qv[31:0];
        end
    endtask

    // Issue one operation and check latency, handshake and result.
    // With disturb set, a start and an MTHI are driven mid-run and must be ignored.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit disturb);
        logic [31:0] e_hi, e_lo;
        logic        e_dbz;
        int          lat;
        bit          busy_ok;
        model(o, x, y, e_hi, e_lo, e_dbz);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);                    // E0
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        busy_ok = busy && !done;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (disturb && k == 10) begin
                start = 1'b1; op = 2'd1; mthi = 1'b1; wdata = 32'h1234;
            end
            if (disturb && k == 11) begin
                start = 1'b0; mthi = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        // done is visible after the 33rd edge following the start edge.
        check({tag, " latency"}, lat, 33);
        check({tag, " busy_during"}, busy_ok, 1);
        check({tag, " hi"}, hi, e_hi);
        check({tag, " lo"}, lo, e_lo);
        check({tag, " div_by_zero"}, div_by_zero, e_dbz);
        @(posedge clk);
        @(negedge clk);
        check({tag, " done_after"}, done, 0);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " dbz_after"}, div_by_zero, 0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b, r_w;
        bit          saw_done;

        rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dbz", div_by_zero, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        rst_n = 1'b1;

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max hi const", hi, 32'hFFFF_FFFE);
        check("multu_max lo const", lo, 32'h0000_0001);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_neg lo const", lo, 32'hFFFF_FFEB);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg lo const", lo, 32'hFFFF_FFFD);
        run_op("divu_zero", 2'd3, 32'd100, 32'd0, 1'b0);
        check("divu_zero hi const", hi, 32'd100);
        run_op("div_zero_neg", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf lo const", lo, 32'h8000_0000);
        run_op("divu_disturb", 2'd3, 32'd100, 32'd7, 1'b1);
        check("divu_disturb hi const", hi, 32'd2);
        check("divu_disturb lo const", lo, 32'd14);

        // MTLO in IDLE.
        @(negedge clk);
        mtlo = 1'b1; wdata = 32'h55;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo lo", lo, 32'h55);
        check("mtlo hi kept", hi, 32'd2);

        // MTHI and MTLO together.
        r_w = $urandom;
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = r_w;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo hi", hi, r_w);
        check("mthilo lo", lo, r_w);

        // Reset part-way through a multiply: nothing commits.
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", busy, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort no_done", saw_done, 0);
        run_op("divu_after_rst", 2'd3, 32'd9, 32'd4, 1'b0);

        // Random operations against the model.
        for (int i = 0; i < 20; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = 32'($urandom_range(0, 3));
                1:       r_b = -32'($urandom_range(1, 3));
                default: r_b = $urandom;
            endcase
            run_op("rand", r_op, r_a, r_b, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
